// File: rtl/des_key_schedule_if.sv
// Purpose: subkey handshake bundle between the key schedule and its consumer.
// Latency: none (plain signal bundle).
// Backpressure: sk_valid/sk_ready, with the producer holding sk_out until accepted.
// Ports: start/key_din/decrypt  load a key and choose issue order.
//        sk_out/sk_valid/sk_round/sk_ready  subkey stream.
//        busy/done  generation status.
interface des_key_schedule_if;
    logic        start;
    logic [63:0] key_din;
    logic        decrypt;
    logic        sk_ready;
    logic [47:0] sk_out;
    logic        sk_valid;
    logic [3:0]  sk_round;
    logic        busy;
    logic        done;

    // Drives the key schedule (key source plus subkey consumer).
    modport master (
        output start, key_din, decrypt, sk_ready,
        input  sk_out, sk_valid, sk_round, busy, done
    );

    // The key schedule itself.
    modport slave (
        input  start, key_din, decrypt, sk_ready,
        output sk_out, sk_valid, sk_round, busy, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// Purpose: DES round-subkey generator; PC-1 on start, then 16 PC-2 subkeys by rotating C/D.
// Latency: start at edge T -> first subkey valid after T+2; done pulse after T+18 with sk_ready=1.
// Backpressure: sk_valid/sk_ready; sk_out is held from registers while sk_ready is low.
// Ports: clk, rst_n (async, active-low); ks = des_key_schedule_if.slave
//        (start, key_din, decrypt, sk_ready in; sk_out, sk_valid, sk_round, busy, done out).
module des_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    des_key_schedule_if.slave    ks
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    // Tables hold DES 1-based bit numbers; bit n of a k-bit vector is vector[k-n].
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1_TAB[j]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2_TAB[j]];
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd0:    r = x;
            2'd1:    r = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
            default: r = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
        endcase
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [27:0] c_q, c_nxt, d_q, d_nxt;
    logic        mode_q, mode_nxt;      // 1: decrypt order
    logic        primed_q, primed_nxt;  // first GEN cycle only settles
    logic [3:0]  rnd_q, rnd_nxt;
    logic [47:0] sk_q, sk_nxt;
    logic        vld_q, vld_nxt;
    logic [3:0]  slot_q, slot_nxt;
    logic        done_q, done_nxt;
    logic [1:0]  shamt;
    logic [27:0] c_rot, d_rot;
    logic        slot_free;

    // Decrypt walks the encrypt schedule backwards: right-rotate by the shift
    // that produced the previous subkey, starting with 0 since the encrypt
    // shifts total 28 and PC1 itself is already the K16 C/D state.
    always_comb begin
        shamt = 2'd2;
        if (mode_q) begin
            if (rnd_q == 4'd0) shamt = 2'd0;
            else if (rnd_q == 4'd1 || rnd_q == 4'd8 || rnd_q == 4'd15) shamt = 2'd1;
        end else begin
            if (rnd_q == 4'd0 || rnd_q == 4'd1 || rnd_q == 4'd8 || rnd_q == 4'd15) shamt = 2'd1;
        end
    end

    assign c_rot     = rot28(c_q, mode_q, shamt);
    assign d_rot     = rot28(d_q, mode_q, shamt);
    assign slot_free = !vld_q || ks.sk_ready;

    always_comb begin
        state_nxt  = state;
        c_nxt      = c_q;
        d_nxt      = d_q;
        mode_nxt   = mode_q;
        primed_nxt = primed_q;
        rnd_nxt    = rnd_q;
        sk_nxt     = sk_q;
        vld_nxt    = vld_q;
        slot_nxt   = slot_q;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ks.start) begin
                    {c_nxt, d_nxt} = pc1(ks.key_din);
                    mode_nxt       = ks.decrypt;
                    rnd_nxt        = 4'd0;
                    primed_nxt     = 1'b0;
                    state_nxt      = GEN;
                end
            end
            GEN: begin
                if (!primed_q) begin
                    primed_nxt = 1'b1;
                end else if (slot_free) begin
                    c_nxt    = c_rot;
                    d_nxt    = d_rot;
                    sk_nxt   = pc2({c_rot, d_rot});
                    vld_nxt  = 1'b1;
                    slot_nxt = rnd_q;
                    rnd_nxt  = rnd_q + 4'd1;
                    if (rnd_q == LAST_RND) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (ks.sk_ready) begin
                    vld_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            mode_q   <= 1'b0;
            primed_q <= 1'b0;
            rnd_q    <= '0;
            sk_q     <= '0;
            vld_q    <= 1'b0;
            slot_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            c_q      <= c_nxt;
            d_q      <= d_nxt;
            mode_q   <= mode_nxt;
            primed_q <= primed_nxt;
            rnd_q    <= rnd_nxt;
            sk_q     <= sk_nxt;
            vld_q    <= vld_nxt;
            slot_q   <= slot_nxt;
            done_q   <= done_nxt;
        end
    end

    assign ks.sk_out   = sk_q;
    assign ks.sk_valid = vld_q;
    assign ks.sk_round = slot_q;
    assign ks.done     = done_q;
    assign ks.busy     = (state != IDLE);

endmodule

// File: tb/tb_des_key_schedule.sv
// Purpose: self-checking bench for des_key_schedule against a cumulative-shift DES key model.
// Latency: checks first-valid at T+2 and done at T+18 for full-rate runs.
// Backpressure: random sk_ready; held subkeys must stay stable.
module tb_des_key_schedule;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    des_key_schedule_if ifc ();

    des_key_schedule #(.NUM_ROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Standard DES schedule: Kn uses C/D left-rotated by the running shift total.
    // Decrypt order is simply the encrypt list reversed.
    function automatic void ref_keys(input logic [63:0] key, input logic dec, output logic [47:0] ks [16]);
        bit kb [1:64];
        bit cd [1:56];
        int tot;
        int p;
        int src;
        logic [47:0] k;
        for (int i = 1; i <= 64; i++) kb[i] = key[64-i];
        for (int j = 1; j <= 56; j++) cd[j] = kb[M_PC1[j-1]];
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += M_SHIFT[r];
            k = '0;
            for (int j = 1; j <= 48; j++) begin
                p = M_PC2[j-1];
                if (p <= 28) src = ((p - 1 + tot) % 28) + 1;
                else         src = ((p - 29 + tot) % 28) + 29;
                k[48-j] = cd[src];
            end
            ks[dec ? 15 - r : r] = k;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [63:0] key, input logic dec, input int rdy_pct,
                       input bit timing, input bit mid_start, input int abort_n,
                       output logic [47:0] got [16]);
        logic [47:0] exp [16];
        int          n;
        int          cyc;
        int          first_vld;
        int          done_cyc;
        bit          hold;
        bit          rdy;
        logic [47:0] prev_out;
        logic [3:0]  prev_rnd;
        ref_keys(key, dec, exp);
        for (int i = 0; i < 16; i++) got[i] = '0;
        n = 0; first_vld = -1; done_cyc = -1; hold = 0; prev_out = '0; prev_rnd = '0;
        ifc.key_din  = key;
        ifc.decrypt  = dec;
        ifc.start    = 1'b1;
        ifc.sk_ready = 1'b0;
        @(posedge clk); #1;
        ifc.start   = 1'b0;
        ifc.key_din = {$urandom, $urandom};
        ifc.decrypt = ~dec;
        chk("busy_after_start", ifc.busy, 1);
        cyc = 0;
        while (done_cyc < 0 && cyc < 600) begin
            if (ifc.done) begin
                done_cyc = cyc;
                chk("busy_at_done", ifc.busy, 0);
                chk("handshakes_at_done", n, 16);
            end else begin
                if (hold) begin
                    chk("hold_valid", ifc.sk_valid, 1);
                    chk("hold_out", ifc.sk_out, prev_out);
                    chk("hold_round", ifc.sk_round, prev_rnd);
                end
                if (ifc.sk_valid && first_vld < 0) first_vld = cyc;
                rdy = ($urandom_range(99) < rdy_pct);
                ifc.sk_ready = rdy;
                if (ifc.sk_valid && rdy) begin
                    if (n < 16) begin
                        got[n] = ifc.sk_out;
                        chk("subkey", ifc.sk_out, exp[n]);
                        chk("sk_round", ifc.sk_round, n);
                    end
                    n++;
                end
                hold     = ifc.sk_valid && !rdy;
                prev_out = ifc.sk_out;
                prev_rnd = ifc.sk_round;
                ifc.start = mid_start && (cyc == 5);
                if (mid_start && cyc == 5) ifc.key_din = ~key;
                if (abort_n >= 0 && n == abort_n) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_sk_valid", ifc.sk_valid, 0);
                    chk("abort_sk_out", ifc.sk_out, 0);
                    chk("abort_sk_round", ifc.sk_round, 0);
                    chk("abort_busy", ifc.busy, 0);
                    chk("abort_done", ifc.done, 0);
                    ifc.sk_ready = 1'b0;
                    ifc.start    = 1'b0;
                    repeat (2) @(posedge clk);
                    #2;
                    rst_n = 1'b1;
                    repeat (3) begin
                        @(posedge clk); #1;
                        chk("abort_no_done", ifc.done, 0);
                        chk("abort_idle", ifc.busy, 0);
                    end
                    return;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("done_seen", done_cyc >= 0, 1);
        if (timing) begin
            chk("first_valid_cycle", first_vld, 2);
            chk("done_cycle", done_cyc, 18);
        end
        ifc.sk_ready = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", ifc.done, 0);
        chk("valid_after_done", ifc.sk_valid, 0);
    endtask

    initial begin
        logic [47:0] g1 [16];
        logic [47:0] g2 [16];
        logic [47:0] g3 [16];
        logic [47:0] gx [16];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifc.start    = 1'b0;
        ifc.key_din  = '0;
        ifc.decrypt  = 1'b0;
        ifc.sk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sk_out", ifc.sk_out, 0);
        chk("rst_sk_valid", ifc.sk_valid, 0);
        chk("rst_sk_round", ifc.sk_round, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer encrypt order, full rate.
        run(KEY_A, 1'b0, 100, 1'b1, 1'b0, -1, g1);
        chk("kat_enc_slot0", g1[0], 48'h1B02EFFC7072);
        chk("kat_enc_slot1", g1[1], 48'h79AED9DBC9E5);
        chk("kat_enc_slot15", g1[15], 48'hCB3D8B0E17F5);

        // Decrypt order is the exact reverse.
        run(KEY_A, 1'b1, 100, 1'b1, 1'b0, -1, g2);
        chk("kat_dec_slot0", g2[0], 48'hCB3D8B0E17F5);
        chk("kat_dec_slot15", g2[15], 48'h1B02EFFC7072);
        for (int i = 0; i < 16; i++) chk("dec_is_reverse", g2[i], g1[15-i]);

        // Parity-only key gives all-zero subkeys.
        run(64'h0101010101010101, 1'b0, 100, 1'b1, 1'b0, -1, g3);
        for (int i = 0; i < 16; i++) chk("parity_key_zero", g3[i], 0);

        // Random backpressure.
        run(KEY_A, 1'b0, 50, 1'b0, 1'b0, -1, gx);
        run(KEY_A, 1'b1, 35, 1'b0, 1'b0, -1, gx);

        // Start mid-generation is ignored.
        run(KEY_A, 1'b0, 100, 1'b1, 1'b1, -1, gx);

        // Reset during generation, then a fresh full sequence.
        run(KEY_A, 1'b0, 100, 1'b0, 1'b0, 7, gx);
        run(KEY_A, 1'b0, 100, 1'b1, 1'b0, -1, gx);

        // Random keys, orders and ready rates.
        repeat (6) begin
            run({$urandom, $urandom}, 1'($urandom_range(1)), int'($urandom_range(100, 30)),
                1'b0, 1'b0, -1, gx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
